// File: rtl/reel_display.sv
// ----------------------------------------------------------------------------
// reel_display
//
// Display-side consumer of the slot-machine engine. Each accepted spin makes
// the three reels cycle through symbol codes. The reels then stop one at a
// time from left to right, and each reel latches its final code from the
// engine's symbol bus as it stops. A free-running scanner time-multiplexes
// the three reel values onto a single symbol output. The win indicator stays
// dark while an animation is running, so the result is never shown early.
//
// Optional feature (macro WIN_BLINK_EN):
//   defined   : win_led = win & win_blink while idle (flashing indicator)
//   undefined : win_led = win while idle (steady indicator), win_blink unused
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   spin_start  single-cycle pulse, spin accepted by the engine
//   symbols     final symbols, reel i = symbols[4i+3:4i]
//   win         engine win flag
//   win_blink   engine win blink toggle
//   busy        high while the animation runs (SPIN or DONE)
//   anim_done   single-cycle pulse once all reels have stopped
//   disp_sel    one-hot display position select (bit i = reel i)
//   disp_sym    symbol code for the selected position
//   win_led     win indicator
// ----------------------------------------------------------------------------
module reel_display #(
    parameter int NUM_SYMBOLS   = 7,
    parameter int STEP_CLKS     = 250000,
    parameter int SPIN_STEPS    = 16,
    parameter int STAGGER_STEPS = 8,
    parameter int SCAN_CLKS     = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spin_start,
    input  logic [11:0] symbols,
    input  logic        win,
    input  logic        win_blink,
    output logic        busy,
    output logic        anim_done,
    output logic [2:0]  disp_sel,
    output logic [3:0]  disp_sym,
    output logic        win_led
);

    localparam int STEP_W = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
    localparam int CNT_W  = $clog2(SPIN_STEPS + 2 * STAGGER_STEPS + 1);
    localparam int SCAN_W = (SCAN_CLKS > 1) ? $clog2(SCAN_CLKS) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SPIN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Step counts at which each reel stops.
    localparam logic [CNT_W-1:0] STOP0 = CNT_W'(SPIN_STEPS);
    localparam logic [CNT_W-1:0] STOP1 = CNT_W'(SPIN_STEPS + STAGGER_STEPS);
    localparam logic [CNT_W-1:0] STOP2 = CNT_W'(SPIN_STEPS + 2 * STAGGER_STEPS);

    logic [1:0]        state_r, state_nxt_s;
    logic [STEP_W-1:0] presc_r, presc_nxt_s;
    logic [CNT_W-1:0]  step_r, step_nxt_s, step_inc_s;
    logic [3:0]        reel0_r, reel1_r, reel2_r;
    logic [3:0]        reel0_nxt_s, reel1_nxt_s, reel2_nxt_s;
    logic              tick_s;
    logic              done_nxt_s;
    logic              win_led_nxt_s;
    logic [SCAN_W-1:0] scan_cnt_r, scan_cnt_nxt_s;
    logic              scan_tc_s;
    logic [2:0]        sel_nxt_s;
    logic [3:0]        sym_nxt_s;

    // Next animation frame: count up, wrapping the top code back to zero.
    function automatic logic [3:0] advance(input logic [3:0] v);
        if (v >= 4'(NUM_SYMBOLS - 1)) begin
            return 4'd0;
        end else begin
            return v + 4'd1;
        end
    endfunction

    // Reel update on a tick: a running reel either advances or latches its
    // final code. A reel that has already stopped keeps its value.
    function automatic logic [3:0] reel_step(
        input logic [3:0]       cur,
        input logic [CNT_W-1:0] step_now,
        input logic [CNT_W-1:0] step_new,
        input logic [CNT_W-1:0] stop_at,
        input logic [3:0]       final_sym
    );
        if (step_now >= stop_at) begin
            return cur;
        end else if (step_new == stop_at) begin
            return final_sym;
        end else begin
            return advance(cur);
        end
    endfunction

    assign tick_s     = (state_r == ST_SPIN) && (presc_r == STEP_W'(STEP_CLKS - 1));
    assign step_inc_s = step_r + CNT_W'(1);

    // Animation state machine, prescaler, step counter and reel values.
    always_comb begin
        state_nxt_s = state_r;
        presc_nxt_s = presc_r;
        step_nxt_s  = step_r;
        reel0_nxt_s = reel0_r;
        reel1_nxt_s = reel1_r;
        reel2_nxt_s = reel2_r;
        done_nxt_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (spin_start) begin
                    state_nxt_s = ST_SPIN;
                    presc_nxt_s = '0;
                    step_nxt_s  = '0;
                    reel0_nxt_s = 4'd0;
                    reel1_nxt_s = 4'd2;
                    reel2_nxt_s = 4'd4;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SPIN: begin
                // A spin_start that arrives here is ignored: nothing in this
                // branch looks at it.
                if (tick_s) begin
                    presc_nxt_s = '0;
                    step_nxt_s  = step_inc_s;
                    reel0_nxt_s = reel_step(reel0_r, step_r, step_inc_s, STOP0, symbols[3:0]);
                    reel1_nxt_s = reel_step(reel1_r, step_r, step_inc_s, STOP1, symbols[7:4]);
                    reel2_nxt_s = reel_step(reel2_r, step_r, step_inc_s, STOP2, symbols[11:8]);
                    if (step_inc_s == STOP2) begin
                        state_nxt_s = ST_DONE;
                        done_nxt_s  = 1'b1;
                    end else begin
                        state_nxt_s = ST_SPIN;
                    end
                end else begin
                    presc_nxt_s = presc_r + STEP_W'(1);
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Win indicator. It is derived from the next state so that it lights on
    // the same edge on which the machine returns to idle.
`ifdef WIN_BLINK_EN
    always_comb begin
        win_led_nxt_s = win && win_blink && (state_nxt_s == ST_IDLE);
    end
`else
    logic unused_blink_s;
    assign unused_blink_s = win_blink;

    always_comb begin
        win_led_nxt_s = win && (state_nxt_s == ST_IDLE);
    end
`endif

    // Display scanner. The symbol is taken from the position that is about to
    // be selected, using the reel values being written on the same edge, so
    // that disp_sel and disp_sym always refer to the same reel.
    always_comb begin
        scan_tc_s = (scan_cnt_r == SCAN_W'(SCAN_CLKS - 1));
        if (scan_tc_s) begin
            scan_cnt_nxt_s = '0;
            sel_nxt_s      = {disp_sel[1:0], disp_sel[2]};
        end else begin
            scan_cnt_nxt_s = scan_cnt_r + SCAN_W'(1);
            sel_nxt_s      = disp_sel;
        end
        case (sel_nxt_s)
            3'b001:  sym_nxt_s = reel0_nxt_s;
            3'b010:  sym_nxt_s = reel1_nxt_s;
            3'b100:  sym_nxt_s = reel2_nxt_s;
            default: sym_nxt_s = 4'd0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            presc_r    <= '0;
            step_r     <= '0;
            reel0_r    <= 4'd0;
            reel1_r    <= 4'd0;
            reel2_r    <= 4'd0;
            busy       <= 1'b0;
            anim_done  <= 1'b0;
            win_led    <= 1'b0;
            scan_cnt_r <= '0;
            disp_sel   <= 3'b001;
            disp_sym   <= 4'd0;
        end else begin
            state_r    <= state_nxt_s;
            presc_r    <= presc_nxt_s;
            step_r     <= step_nxt_s;
            reel0_r    <= reel0_nxt_s;
            reel1_r    <= reel1_nxt_s;
            reel2_r    <= reel2_nxt_s;
            busy       <= (state_nxt_s != ST_IDLE);
            anim_done  <= done_nxt_s;
            win_led    <= win_led_nxt_s;
            scan_cnt_r <= scan_cnt_nxt_s;
            disp_sel   <= sel_nxt_s;
            disp_sym   <= sym_nxt_s;
        end
    end

endmodule
